// File: rtl/evo_pkg.sv
// Shared types and defaults for the truth-table scoring sequencer.
// score_width sizes the error counter so the all-bits-wrong sweep still fits.
package evo_pkg;

  localparam int N_IN_DEF          = 4;
  localparam int N_OUT_DEF         = 4;
  localparam int SETTLE_CYCLES_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  function automatic int score_width(input int n_in, input int n_out);
    return $clog2((1 << n_in) * n_out + 1);
  endfunction

endpackage

// File: rtl/truth_table_scorer_bit_popcount.sv
// Purely combinational population count of a W-bit vector.
module bit_popcount #(
  parameter int W = 4,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/truth_table_scorer.sv
// Sweeps every input vector onto an evolved candidate netlist, waits a settle
// window, and accumulates mismatched output bits against a stored target table.
module truth_table_scorer
  import evo_pkg::*;
#(
  parameter int N_IN          = N_IN_DEF,
  parameter int N_OUT         = N_OUT_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  localparam int SCORE_W      = score_width(N_IN, N_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               exp_we,
  input  logic [N_IN-1:0]    exp_addr,
  input  logic [N_OUT-1:0]   exp_data,
  output logic [N_IN-1:0]    cand_in,
  input  logic [N_OUT-1:0]   cand_out,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic               perfect
);

  localparam int DEPTH = 1 << N_IN;
  localparam int PC_W  = $clog2(N_OUT + 1);

  // Host protocol: start is a level sampled only in IDLE (no queueing); busy is
  // high while a sweep runs; done pulses for one cycle with score already final.
  state_e             state;
  logic [7:0]         settle_cnt;
  logic [N_OUT-1:0]   tbl [DEPTH];
  logic [N_OUT-1:0]   miss;
  logic [PC_W-1:0]    miss_cnt;

  assign miss = cand_out ^ tbl[cand_in];
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  bit_popcount #(.W(N_OUT)) u_popcount (
    .bits  (miss),
    .count (miss_cnt)
  );

  // Table is frozen outside IDLE so a sweep always scores against one target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else if (state == S_IDLE && exp_we) begin
      tbl[exp_addr] <= exp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      cand_in    <= '0;
      score      <= '0;
      perfect    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cand_in    <= '0;
            score      <= '0;
            perfect    <= 1'b0;
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        S_SAMPLE: begin
          score <= score + SCORE_W'(miss_cnt);
          if (&cand_in) begin
            state <= S_DONE;
          end else begin
            cand_in    <= cand_in + N_IN'(1);
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
        end
        S_DONE: begin
          perfect <= (score == '0);
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
